// File: rtl/traffic_light_monitor_if.sv
// Lamp-drive lines seen by the monitor plus the monitor's status outputs.
// The controller side (master) drives the lamps; the monitor (slave) only observes them.
interface traffic_light_monitor_if;
  logic        lamp_red;
  logic        lamp_yellow;
  logic        lamp_green;
  logic        locked;
  logic        err_valid;
  logic [2:0]  err_code;
  logic [7:0]  err_count;
  logic [15:0] cycles_completed;

  modport master (
    output lamp_red, lamp_yellow, lamp_green,
    input  locked, err_valid, err_code, err_count, cycles_completed
  );

  modport slave (
    input  lamp_red, lamp_yellow, lamp_green,
    output locked, err_valid, err_code, err_count, cycles_completed
  );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive traffic-light checker: tracks red->green->yellow order and per-phase dwell time,
// reporting violations as registered one-cycle coded pulses with a saturating count.
module traffic_light_monitor #(
  parameter int unsigned RED_LENGTH    = 15,
  parameter int unsigned YELLOW_LENGTH = 5,
  parameter int unsigned GREEN_LENGTH  = 15,
  parameter int unsigned TOLERANCE     = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  traffic_light_monitor_if.slave  mon
);

  localparam int unsigned MaxRg  = (RED_LENGTH > GREEN_LENGTH) ? RED_LENGTH : GREEN_LENGTH;
  localparam int unsigned MaxLen = (MaxRg > YELLOW_LENGTH) ? MaxRg : YELLOW_LENGTH;
  localparam int unsigned MinRg  = (RED_LENGTH < GREEN_LENGTH) ? RED_LENGTH : GREEN_LENGTH;
  localparam int unsigned MinLen = (MinRg < YELLOW_LENGTH) ? MinRg : YELLOW_LENGTH;
  localparam int unsigned DwellW = $clog2(MaxLen + TOLERANCE + 2) + 1;

  if (TOLERANCE >= MinLen) begin : g_tol_check
    $error("traffic_light_monitor: TOLERANCE must be smaller than every phase length");
  end

  typedef enum logic [2:0] {PatDark, PatRed, PatYellow, PatGreen, PatMulti} pat_e;
  typedef enum logic {StUnsync, StTrack} state_e;

  localparam logic [2:0] ErrNone     = 3'd0;
  localparam logic [2:0] ErrShort    = 3'd1;
  localparam logic [2:0] ErrLong     = 3'd2;
  localparam logic [2:0] ErrSequence = 3'd3;
  localparam logic [2:0] ErrDark     = 3'd4;
  localparam logic [2:0] ErrIllegal  = 3'd5;

  localparam logic [DwellW-1:0] DwellMax = '1;

  state_e            state_q, state_d;
  pat_e              pat_q, pat_d, pat_in;
  logic [DwellW-1:0] dwell_q, dwell_d;
  logic              partial_q, partial_d;
  logic              long_q, long_d;
  logic              err_valid_q;
  logic [2:0]        err_code_q, err_code_d;
  logic [7:0]        err_count_q;
  logic [15:0]       cycles_q;
  logic              cycle_done;
  logic [DwellW-1:0] len_p, short_thr, long_thr;
  pat_e              succ_p;

  always_comb begin
    pat_in = PatMulti;
    case ({mon.lamp_red, mon.lamp_yellow, mon.lamp_green})
      3'b000:  pat_in = PatDark;
      3'b100:  pat_in = PatRed;
      3'b010:  pat_in = PatYellow;
      3'b001:  pat_in = PatGreen;
      default: pat_in = PatMulti;
    endcase
  end

  // Length and successor of the phase currently held in pat_q.
  always_comb begin
    len_p  = DwellW'(RED_LENGTH);
    succ_p = PatGreen;
    case (pat_q)
      PatGreen: begin
        len_p  = DwellW'(GREEN_LENGTH);
        succ_p = PatYellow;
      end
      PatYellow: begin
        len_p  = DwellW'(YELLOW_LENGTH);
        succ_p = PatRed;
      end
      default: begin
        len_p  = DwellW'(RED_LENGTH);
        succ_p = PatGreen;
      end
    endcase
    short_thr = len_p - DwellW'(TOLERANCE);
    long_thr  = len_p + DwellW'(TOLERANCE);
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    dwell_d    = (dwell_q == DwellMax) ? dwell_q : dwell_q + 1'b1;
    partial_d  = partial_q;
    long_d     = long_q;
    err_code_d = ErrNone;
    cycle_done = 1'b0;

    if (pat_in != pat_q) begin
      pat_d     = pat_in;
      dwell_d   = DwellW'(1);
      partial_d = 1'b0;
      long_d    = 1'b0;
      if (state_q == StUnsync) begin
        if (pat_in == PatMulti) begin
          err_code_d = ErrIllegal;
        end else if (pat_in != PatDark) begin
          state_d   = StTrack;
          // Dark with zero dwell means nothing was observed yet (e.g. just out of reset),
          // so the phase we lock onto may already be partly over.
          partial_d = (pat_q != PatDark) || (dwell_q == '0);
        end
      end else begin
        if (pat_in == PatMulti) begin
          err_code_d = ErrIllegal;
          state_d    = StUnsync;
        end else if (pat_in == PatDark) begin
          err_code_d = ErrDark;
          state_d    = StUnsync;
        end else if (pat_in != succ_p) begin
          err_code_d = ErrSequence;
        end else if ((dwell_q < short_thr) && !partial_q && !long_q) begin
          err_code_d = ErrShort;
        end else if ((pat_q == PatYellow) && !long_q) begin
          cycle_done = 1'b1;
        end
      end
    end else if ((state_q == StTrack) && !long_q && (dwell_q == long_thr)) begin
      err_code_d = ErrLong;
      long_d     = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StUnsync;
      pat_q       <= PatDark;
      dwell_q     <= '0;
      partial_q   <= 1'b0;
      long_q      <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= ErrNone;
      err_count_q <= '0;
      cycles_q    <= '0;
    end else begin
      state_q     <= state_d;
      pat_q       <= pat_d;
      dwell_q     <= dwell_d;
      partial_q   <= partial_d;
      long_q      <= long_d;
      err_valid_q <= (err_code_d != ErrNone);
      err_code_q  <= err_code_d;
      if ((err_code_d != ErrNone) && (err_count_q != 8'hff)) begin
        err_count_q <= err_count_q + 8'd1;
      end
      if (cycle_done) begin
        cycles_q <= cycles_q + 16'd1;
      end
    end
  end

  assign mon.locked           = (state_q == StTrack);
  assign mon.err_valid        = err_valid_q;
  assign mon.err_code         = err_code_q;
  assign mon.err_count        = err_count_q;
  assign mon.cycles_completed = cycles_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor: one task per scenario, hand-computed expectations.
module tb_traffic_light_monitor;

  logic clk = 1'b0;
  logic reset = 1'b1;

  traffic_light_monitor_if bus ();

  traffic_light_monitor dut (
    .clk   (clk),
    .reset (reset),
    .mon   (bus)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] D  = 3'b000;
  localparam logic [2:0] R  = 3'b100;
  localparam logic [2:0] Y  = 3'b010;
  localparam logic [2:0] G  = 3'b001;
  localparam logic [2:0] RG = 3'b101;

  int passed = 0;
  int total = 0;
  int pulses;
  int pulse_at;
  logic [2:0] last_code;

  // Lamps change just after an edge; outputs are read 1 ns after the sampling edge.
  task automatic step(input logic [2:0] p);
    {bus.lamp_red, bus.lamp_yellow, bus.lamp_green} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    pulses = 0;
    pulse_at = 0;
    last_code = 3'd0;
  endtask

  task automatic hold(input logic [2:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      step(p);
      if (bus.err_valid) begin
        pulses++;
        pulse_at = i + 1;
        last_code = bus.err_code;
      end
    end
  endtask

  task automatic do_reset(input logic [2:0] p);
    reset = 1'b1;
    step(p);
    step(p);
    reset = 1'b0;
    clear_pulses();
  endtask

  task automatic test_reset();
    do_reset(D);
    total++; if (bus.locked !== 1'b0) $display("FAIL reset_locked: got %0b want 0", bus.locked); else passed++;
    total++; if (bus.err_valid !== 1'b0) $display("FAIL reset_err_valid: got %0b want 0", bus.err_valid); else passed++;
    total++; if (bus.err_code !== 3'd0) $display("FAIL reset_err_code: got %0d want 0", bus.err_code); else passed++;
    total++; if (bus.err_count !== 8'd0) $display("FAIL reset_err_count: got %0d want 0", bus.err_count); else passed++;
    total++; if (bus.cycles_completed !== 16'd0) $display("FAIL reset_cycles: got %0d want 0", bus.cycles_completed); else passed++;
  endtask

  task automatic test_defaults();
    do_reset(D);
    hold(D, 3);
    hold(R, 1);
    total++; if (bus.locked !== 1'b1) $display("FAIL defaults_lock_first_red: got %0b want 1", bus.locked); else passed++;
    hold(R, 14); hold(G, 15); hold(Y, 5);
    hold(R, 15); hold(G, 15); hold(Y, 5);
    hold(R, 1);
    total++; if (pulses !== 0) $display("FAIL defaults_no_error: got %0d pulses want 0", pulses); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL defaults_locked: got %0b want 1", bus.locked); else passed++;
    total++; if (bus.cycles_completed !== 16'd2) $display("FAIL defaults_cycles: got %0d want 2", bus.cycles_completed); else passed++;
  endtask

  task automatic test_short_green();
    do_reset(D);
    hold(D, 3); hold(R, 15); hold(G, 14);
    clear_pulses();
    hold(Y, 1);
    total++; if (pulses !== 1 || last_code !== 3'd1) $display("FAIL short_green_pulse: got %0d pulses code %0d want 1 code 1", pulses, last_code); else passed++;
    total++; if (bus.err_count !== 8'd1) $display("FAIL short_green_count: got %0d want 1", bus.err_count); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL short_green_locked: got %0b want 1", bus.locked); else passed++;
    hold(Y, 1);
    total++; if (bus.err_valid !== 1'b0 || bus.err_code !== 3'd0) $display("FAIL short_green_single: got valid %0b code %0d want 0 0", bus.err_valid, bus.err_code); else passed++;
  endtask

  task automatic test_long_yellow();
    do_reset(D);
    hold(D, 3); hold(R, 15); hold(G, 15);
    clear_pulses();
    hold(Y, 8);
    total++; if (pulses !== 1 || last_code !== 3'd2) $display("FAIL long_yellow_pulse: got %0d pulses code %0d want 1 code 2", pulses, last_code); else passed++;
    total++; if (pulse_at !== 6) $display("FAIL long_yellow_timing: got sample %0d want 6", pulse_at); else passed++;
    clear_pulses();
    hold(R, 1);
    total++; if (pulses !== 0) $display("FAIL long_yellow_to_red: got %0d pulses want 0", pulses); else passed++;
    total++; if (bus.cycles_completed !== 16'd0) $display("FAIL long_yellow_cycles: got %0d want 0", bus.cycles_completed); else passed++;
  endtask

  task automatic test_sequence();
    do_reset(D);
    hold(D, 3); hold(R, 15);
    clear_pulses();
    hold(Y, 1);
    total++; if (pulses !== 1 || last_code !== 3'd3 || pulse_at !== 1) $display("FAIL sequence_pulse: got %0d pulses code %0d at %0d want 1 code 3 at 1", pulses, last_code, pulse_at); else passed++;
    total++; if (bus.locked !== 1'b1) $display("FAIL sequence_locked: got %0b want 1", bus.locked); else passed++;
    clear_pulses();
    hold(Y, 4); hold(R, 1);
    total++; if (pulses !== 0) $display("FAIL sequence_resync: got %0d pulses want 0", pulses); else passed++;
    total++; if (bus.cycles_completed !== 16'd1) $display("FAIL sequence_cycles: got %0d want 1", bus.cycles_completed); else passed++;
  endtask

  task automatic test_partial();
    do_reset(R);
    hold(R, 1);
    total++; if (bus.locked !== 1'b1) $display("FAIL partial_lock: got %0b want 1", bus.locked); else passed++;
    hold(R, 3); hold(G, 1);
    total++; if (pulses !== 0) $display("FAIL partial_no_short: got %0d pulses code %0d want 0", pulses, last_code); else passed++;
  endtask

  task automatic test_drop_lock();
    do_reset(D);
    hold(D, 3); hold(R, 5);
    clear_pulses();
    hold(RG, 1);
    total++; if (pulses !== 1 || last_code !== 3'd5) $display("FAIL illegal_pulse: got %0d pulses code %0d want 1 code 5", pulses, last_code); else passed++;
    total++; if (bus.locked !== 1'b0) $display("FAIL illegal_unlock: got %0b want 0", bus.locked); else passed++;
    clear_pulses();
    hold(D, 2); hold(R, 15); hold(G, 1);
    total++; if (pulses !== 0 || bus.locked !== 1'b1) $display("FAIL relock: got %0d pulses locked %0b want 0 pulses locked 1", pulses, bus.locked); else passed++;
    hold(G, 5);
    clear_pulses();
    hold(D, 1);
    total++; if (pulses !== 1 || last_code !== 3'd4) $display("FAIL dark_pulse: got %0d pulses code %0d want 1 code 4", pulses, last_code); else passed++;
    total++; if (bus.locked !== 1'b0) $display("FAIL dark_unlock: got %0b want 0", bus.locked); else passed++;
    total++; if (bus.err_count !== 8'd2) $display("FAIL drop_lock_count: got %0d want 2", bus.err_count); else passed++;
  endtask

  task automatic test_saturate_and_reset();
    do_reset(D);
    hold(D, 3); hold(R, 15); hold(G, 15); hold(Y, 5);
    clear_pulses();
    for (int k = 0; k < 300; k++) begin
      hold(R, 3); hold(G, 15); hold(Y, 5);
    end
    total++; if (pulses !== 300) $display("FAIL saturate_pulses: got %0d want 300", pulses); else passed++;
    total++; if (bus.err_count !== 8'd255) $display("FAIL saturate_count: got %0d want 255", bus.err_count); else passed++;
    total++; if (bus.cycles_completed !== 16'd300) $display("FAIL saturate_cycles: got %0d want 300", bus.cycles_completed); else passed++;
    hold(R, 15); hold(G, 5);
    total++; if (bus.locked !== 1'b1) $display("FAIL pre_reset_locked: got %0b want 1", bus.locked); else passed++;
    reset = 1'b1;
    step(G);
    total++; if ({bus.locked, bus.err_valid, bus.err_code} !== 5'd0) $display("FAIL mid_reset_status: got %0b want 00000", {bus.locked, bus.err_valid, bus.err_code}); else passed++;
    total++; if (bus.err_count !== 8'd0 || bus.cycles_completed !== 16'd0) $display("FAIL mid_reset_counts: got %0d %0d want 0 0", bus.err_count, bus.cycles_completed); else passed++;
    reset = 1'b0;
  endtask

  initial begin
    {bus.lamp_red, bus.lamp_yellow, bus.lamp_green} = D;
    clear_pulses();
    test_reset();
    test_defaults();
    test_short_green();
    test_long_yellow();
    test_sequence();
    test_partial();
    test_drop_lock();
    test_saturate_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
